// File: rtl/voice_alloc_pkg.sv
// Shared types for the polyphonic voice allocator.
// FSM states, commit actions and the per-voice record.
package voice_alloc_pkg;

   localparam int unsigned VA_KEY_W  = 7;
   localparam int unsigned VA_FREQ_W = 24;
   localparam int unsigned VA_AGE_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_WAIT_TICK,
      ST_GAP
   } state_e;

   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_RETRIG,
      ACT_ALLOC,
      ACT_STEAL,
      ACT_RELEASE
   } action_e;

   typedef struct packed {
      logic [VA_KEY_W-1:0]  key;
      logic [VA_FREQ_W-1:0] freq;
      logic [VA_AGE_W-1:0]  age;
      logic                 active;
      logic                 pending;
   } voice_rec_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake between the event source and
// the voice allocator.
interface voice_allocator_if
   import voice_alloc_pkg::*;
#(
   parameter int KEY_W  = VA_KEY_W,
   parameter int FREQ_W = VA_FREQ_W
);
   logic              ev_valid;
   logic              ev_ready;
   logic              ev_note_on;
   logic [KEY_W-1:0]  ev_key;
   logic [FREQ_W-1:0] ev_freq;

   modport master (
      output ev_valid, ev_note_on, ev_key, ev_freq,
      input  ev_ready
   );

   modport slave (
      input  ev_valid, ev_note_on, ev_key, ev_freq,
      output ev_ready
   );
endinterface

// File: rtl/voice_slot.sv
// One synth voice's bookkeeping registers.
// CS is low while inactive or while a steal gap is pending.
module voice_slot
   import voice_alloc_pkg::*;
#(
   parameter int KEY_W  = VA_KEY_W,
   parameter int FREQ_W = VA_FREQ_W,
   parameter int AGE_W  = VA_AGE_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              wr_i,
   input  action_e           act_i,
   input  logic [KEY_W-1:0]  key_i,
   input  logic [FREQ_W-1:0] freq_i,
   input  logic              age_inc_i,
   input  logic              gap_done_i,
   output logic              cs_o,
   output logic              active_o,
   output logic [KEY_W-1:0]  key_o,
   output logic [FREQ_W-1:0] freq_o,
   output logic [AGE_W-1:0]  age_o
);

   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   logic [KEY_W-1:0]  key_q, key_d;
   logic [FREQ_W-1:0] freq_q, freq_d;
   logic [AGE_W-1:0]  age_q, age_d;
   logic              active_q, active_d;
   logic              pending_q, pending_d;

   // next voice contents from the committed action or aging
   always_comb begin
      key_d     = key_q;
      freq_d    = freq_q;
      age_d     = age_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (wr_i) begin
         unique case (act_i)
            ACT_RETRIG: begin
               freq_d = freq_i;
               age_d  = '0;
            end
            ACT_ALLOC: begin
               key_d    = key_i;
               freq_d   = freq_i;
               age_d    = '0;
               active_d = 1'b1;
            end
            ACT_STEAL: begin
               key_d     = key_i;
               freq_d    = freq_i;
               age_d     = '0;
               pending_d = 1'b1;
            end
            ACT_RELEASE: active_d = 1'b0;
            default: ;
         endcase
      end else if (gap_done_i) begin
         pending_d = 1'b0;
      end else if (age_inc_i && active_q &&
                   age_q != AGE_MAX) begin
         age_d = age_q + 1'b1;
      end
   end

   // voice registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         key_q     <= '0;
         freq_q    <= '0;
         age_q     <= '0;
         active_q  <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         key_q     <= key_d;
         freq_q    <= freq_d;
         age_q     <= age_d;
         active_q  <= active_d;
         pending_q <= pending_d;
      end
   end

   assign cs_o     = active_q & ~pending_q;
   assign active_o = active_q;
   assign key_o    = key_q;
   assign freq_o   = freq_q;
   assign age_o    = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans voices one per cycle,
// then commits retrig/alloc/steal/release on a sample tick.
module voice_allocator
   import voice_alloc_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int FREQ_W     = VA_FREQ_W,
   parameter int KEY_W      = VA_KEY_W,
   parameter int AGE_W      = VA_AGE_W
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     sample_Clk_i,
   voice_allocator_if.slave         ev_s,
   output logic [NUM_VOICES-1:0]    voice_cs_o,
   output logic [NUM_VOICES*FREQ_W-1:0] voice_freq_o,
   output logic [$clog2(NUM_VOICES+1)-1:0] active_count_o,
   output logic                     busy_o
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int CNT_W = $clog2(NUM_VOICES+1);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES-1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              on_q, on_d;
   logic [KEY_W-1:0]  key_q, key_d;
   logic [FREQ_W-1:0] freq_q, freq_d;
   logic              mf_q, mf_d, ff_q, ff_d, of_q, of_d;
   logic [IDX_W-1:0]  mi_q, mi_d, fi_q, fi_d, oi_q, oi_d;
   logic [AGE_W-1:0]  oa_q, oa_d;
   action_e           act_q, act_d;
   logic [IDX_W-1:0]  tgt_q, tgt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic ready, accept, last_scan;
   logic commit, gap_done;

   logic [NUM_VOICES-1:0] cs_a;
   logic [NUM_VOICES-1:0] active_a;
   logic [KEY_W-1:0]      key_a  [NUM_VOICES];
   logic [FREQ_W-1:0]     freq_a [NUM_VOICES];
   logic [AGE_W-1:0]      age_a  [NUM_VOICES];

   logic             cur_act;
   logic [KEY_W-1:0] cur_key;
   logic [AGE_W-1:0] cur_age;

   assign cur_act = active_a[idx_q];
   assign cur_key = key_a[idx_q];
   assign cur_age = age_a[idx_q];

   assign accept    = ready && ev_s.ev_valid;
   assign last_scan = (state_q == ST_SCAN) && (idx_q == LAST);

   // state register
   always_ff @(posedge Clk) begin
      if (Reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (accept) state_d = ST_SCAN;
         ST_SCAN:
            if (last_scan)
               state_d = (act_d == ACT_NONE) ?
                         ST_IDLE : ST_WAIT_TICK;
         ST_WAIT_TICK:
            if (sample_Clk_i)
               state_d = (act_q == ACT_STEAL) ?
                         ST_GAP : ST_IDLE;
         ST_GAP:
            if (sample_Clk_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: handshake, busy and commit strobes
   always_comb begin
      ready    = (state_q == ST_IDLE);
      busy_o   = (state_q != ST_IDLE);
      commit   = (state_q == ST_WAIT_TICK) && sample_Clk_i;
      gap_done = (state_q == ST_GAP) && sample_Clk_i;
   end

   assign ev_s.ev_ready = ready;

   // scan bookkeeping and the final decision
   always_comb begin
      idx_d  = idx_q;
      on_d   = on_q;
      key_d  = key_q;
      freq_d = freq_q;
      mf_d   = mf_q;
      mi_d   = mi_q;
      ff_d   = ff_q;
      fi_d   = fi_q;
      of_d   = of_q;
      oi_d   = oi_q;
      oa_d   = oa_q;
      act_d  = act_q;
      tgt_d  = tgt_q;
      if (accept) begin
         on_d   = ev_s.ev_note_on;
         key_d  = ev_s.ev_key;
         freq_d = ev_s.ev_freq;
         idx_d  = '0;
         mf_d   = 1'b0;
         ff_d   = 1'b0;
         of_d   = 1'b0;
         mi_d   = '0;
         fi_d   = '0;
         oi_d   = '0;
         oa_d   = '0;
         act_d  = ACT_NONE;
      end else if (state_q == ST_SCAN) begin
         idx_d = idx_q + 1'b1;
         if (cur_act && !mf_q && cur_key == key_q) begin
            mf_d = 1'b1;
            mi_d = idx_q;
         end
         if (!cur_act && !ff_q) begin
            ff_d = 1'b1;
            fi_d = idx_q;
         end
         if (cur_act && (!of_q || cur_age > oa_q)) begin
            of_d = 1'b1;
            oi_d = idx_q;
            oa_d = cur_age;
         end
         if (last_scan) begin
            act_d = ACT_NONE;
            if (on_q) begin
               if (mf_d) begin
                  act_d = ACT_RETRIG;
                  tgt_d = mi_d;
               end else if (ff_d) begin
                  act_d = ACT_ALLOC;
                  tgt_d = fi_d;
               end else begin
                  act_d = ACT_STEAL;
                  tgt_d = oi_d;
               end
            end else if (mf_d) begin
               act_d = ACT_RELEASE;
               tgt_d = mi_d;
            end
         end
      end
   end

   // latched event and scan registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         idx_q  <= '0;
         on_q   <= 1'b0;
         key_q  <= '0;
         freq_q <= '0;
         mf_q   <= 1'b0;
         mi_q   <= '0;
         ff_q   <= 1'b0;
         fi_q   <= '0;
         of_q   <= 1'b0;
         oi_q   <= '0;
         oa_q   <= '0;
         act_q  <= ACT_NONE;
         tgt_q  <= '0;
      end else begin
         idx_q  <= idx_d;
         on_q   <= on_d;
         key_q  <= key_d;
         freq_q <= freq_d;
         mf_q   <= mf_d;
         mi_q   <= mi_d;
         ff_q   <= ff_d;
         fi_q   <= fi_d;
         of_q   <= of_d;
         oi_q   <= oi_d;
         oa_q   <= oa_d;
         act_q  <= act_d;
         tgt_q  <= tgt_d;
      end
   end

   for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_voice
      logic sel;
      assign sel = (tgt_q == IDX_W'(gv));

      voice_slot #(
         .KEY_W  (KEY_W),
         .FREQ_W (FREQ_W),
         .AGE_W  (AGE_W)
      ) u_slot (
         .Clk        (Clk),
         .Reset      (Reset),
         .wr_i       (commit && sel),
         .act_i      (act_q),
         .key_i      (key_q),
         .freq_i     (freq_q),
         .age_inc_i  (commit && !sel &&
                      act_q != ACT_RELEASE),
         .gap_done_i (gap_done && sel),
         .cs_o       (cs_a[gv]),
         .active_o   (active_a[gv]),
         .key_o      (key_a[gv]),
         .freq_o     (freq_a[gv]),
         .age_o      (age_a[gv])
      );

      assign voice_freq_o[gv*FREQ_W +: FREQ_W] = freq_a[gv];
   end

   // population count of active voices
   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         cnt_d = cnt_d + CNT_W'(active_a[i]);
   end

   // registered active count, one cycle behind commit
   always_ff @(posedge Clk) begin
      if (Reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign voice_cs_o     = cs_a;
   assign active_count_o = cnt_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with an event-level
// reference model checked every cycle.
module tb_voice_allocator;
   import voice_alloc_pkg::*;

   localparam int N  = 4;
   localparam int FW = 24;
   localparam int KW = 7;
   localparam int AW = 4;

   logic            Clk = 1'b0;
   logic            Reset = 1'b1;
   logic            sample_Clk = 1'b0;
   logic [N-1:0]    voice_cs;
   logic [N*FW-1:0] voice_freq;
   logic [2:0]      active_count;
   logic            busy;

   voice_allocator_if #(.KEY_W(KW), .FREQ_W(FW)) ev ();

   voice_allocator #(
      .NUM_VOICES (N),
      .FREQ_W     (FW),
      .KEY_W      (KW),
      .AGE_W      (AW)
   ) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .sample_Clk_i   (sample_Clk),
      .ev_s           (ev),
      .voice_cs_o     (voice_cs),
      .voice_freq_o   (voice_freq),
      .active_count_o (active_count),
      .busy_o         (busy)
   );

   always #5 Clk = ~Clk;

   // model: voice table plus in-flight event bookkeeping
   voice_rec_t    mv [N];
   int            m_stage;
   action_e       m_act;
   int            m_tgt;
   int            m_from;
   logic [KW-1:0] m_key;
   logic [FW-1:0] m_freq;
   int            k;
   bit            m_acc;
   int            m_cnt;
   int            errors = 0;
   int            checks = 0;
   bit            chk_en = 0;
   int            samp_cnt = 0;

   task automatic check(string name, logic [127:0] act,
                        logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   function automatic logic [N-1:0] exp_cs();
      logic [N-1:0] r;
      for (int v = 0; v < N; v++)
         r[v] = mv[v].active && !mv[v].pending;
      return r;
   endfunction

   function automatic logic [N*FW-1:0] exp_freq();
      logic [N*FW-1:0] r;
      for (int v = 0; v < N; v++)
         r[v*FW +: FW] = mv[v].freq;
      return r;
   endfunction

   task automatic model_commit();
      if (m_act != ACT_RELEASE)
         for (int v = 0; v < N; v++)
            if (v != m_tgt && mv[v].active &&
                mv[v].age != 4'hF)
               mv[v].age = mv[v].age + 1'b1;
      case (m_act)
         ACT_RETRIG: begin
            mv[m_tgt].freq = m_freq;
            mv[m_tgt].age  = '0;
         end
         ACT_ALLOC: begin
            mv[m_tgt].key    = m_key;
            mv[m_tgt].freq   = m_freq;
            mv[m_tgt].age    = '0;
            mv[m_tgt].active = 1'b1;
         end
         ACT_STEAL: begin
            mv[m_tgt].key     = m_key;
            mv[m_tgt].freq    = m_freq;
            mv[m_tgt].age     = '0;
            mv[m_tgt].pending = 1'b1;
         end
         ACT_RELEASE: mv[m_tgt].active = 1'b0;
         default: ;
      endcase
   endtask

   task automatic model_accept();
      int mt, ft, ot;
      mt = -1; ft = -1; ot = -1;
      m_key  = ev.ev_key;
      m_freq = ev.ev_freq;
      for (int v = 0; v < N; v++) begin
         if (mv[v].active) begin
            if (mt < 0 && mv[v].key == m_key) mt = v;
            if (ot < 0 || mv[v].age > mv[ot].age) ot = v;
         end else if (ft < 0) ft = v;
      end
      m_act = ACT_NONE;
      if (ev.ev_note_on) begin
         if (mt >= 0) begin m_act = ACT_RETRIG; m_tgt = mt; end
         else if (ft >= 0) begin m_act = ACT_ALLOC; m_tgt = ft; end
         else begin m_act = ACT_STEAL; m_tgt = ot; end
      end else if (mt >= 0) begin
         m_act = ACT_RELEASE; m_tgt = mt;
      end
      // scan takes N cycles; earliest commit one cycle later
      m_from  = k + N + 1;
      m_stage = (m_act == ACT_NONE) ? 1 : 2;
   endtask

   // one model step per rising edge, same inputs as the DUT
   task automatic model_step();
      int cnt;
      k++;
      m_acc = 0;
      cnt = 0;
      for (int v = 0; v < N; v++) cnt += int'(mv[v].active);
      if (Reset) begin
         for (int v = 0; v < N; v++) mv[v] = '0;
         m_stage = 0;
         m_cnt = 0;
         return;
      end
      case (m_stage)
         0: if (ev.ev_valid) begin
            m_acc = 1;
            model_accept();
         end
         1: if (k == m_from - 1) m_stage = 0;
         2: if (k >= m_from && sample_Clk) begin
            model_commit();
            m_stage = (m_act == ACT_STEAL) ? 3 : 0;
         end
         3: if (sample_Clk) begin
            mv[m_tgt].pending = 1'b0;
            m_stage = 0;
         end
         default: m_stage = 0;
      endcase
      m_cnt = cnt;
   endtask

   task automatic cyc_s(bit s);
      sample_Clk = s;
      @(posedge Clk);
      model_step();
      #1;
   endtask

   task automatic cyc();
      samp_cnt++;
      cyc_s(samp_cnt % 7 == 0);
   endtask

   task automatic send(bit on, int key, int freq);
      bit got;
      got = 0;
      ev.ev_note_on = on;
      ev.ev_key     = KW'(key);
      ev.ev_freq    = FW'(freq);
      ev.ev_valid   = 1'b1;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (m_acc) begin got = 1; break; end
      end
      ev.ev_valid = 1'b0;
      check("accept_timeout", got, 1'b1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (m_stage == 0) break;
         cyc();
      end
      check("idle_timeout", m_stage == 0, 1'b1);
   endtask

   task automatic wait_gap();
      for (int i = 0; i < 200; i++) begin
         if (m_stage == 3) break;
         cyc();
      end
      check("gap_timeout", m_stage == 3, 1'b1);
   endtask

   // cycle-by-cycle comparison against the model
   initial begin
      forever begin
         @(negedge Clk);
         if (chk_en) begin
            check("cs", voice_cs, exp_cs());
            check("freq", voice_freq, exp_freq());
            check("count", active_count, m_cnt);
            check("busy", busy, m_stage != 0);
            check("ready", ev.ev_ready, m_stage == 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      k = 0;
      m_stage = 0;
      m_cnt = 0;
      for (int v = 0; v < N; v++) mv[v] = '0;
      ev.ev_valid   = 1'b0;
      ev.ev_note_on = 1'b0;
      ev.ev_key     = '0;
      ev.ev_freq    = '0;

      Reset = 1'b1;
      repeat (3) cyc();
      Reset = 1'b0;
      chk_en = 1;
      check("rst_cs", voice_cs, 4'b0000);
      check("rst_ready", ev.ev_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_count", active_count, 3'd0);

      // first allocation
      send(1, 60, 24'h001000);
      wait_idle();
      cyc(); cyc();
      check("t1_cs", voice_cs, 4'b0001);
      check("t1_freq0", voice_freq[23:0], 24'h001000);
      check("t1_count", active_count, 3'd1);

      // fill, release, reuse freed voice
      send(1, 62, 24'h001100); wait_idle();
      send(1, 64, 24'h001200); wait_idle();
      send(1, 67, 24'h001300); wait_idle();
      cyc(); cyc();
      check("t2_cs_full", voice_cs, 4'b1111);
      check("t2_count", active_count, 3'd4);
      send(0, 62, 0); wait_idle();
      check("t2_cs_rel", voice_cs, 4'b1101);
      send(1, 69, 24'h001400); wait_idle();
      check("t2_cs_reuse", voice_cs, 4'b1111);
      check("t2_freq1", voice_freq[47:24], 24'h001400);

      // steal oldest (voice 0) with one-tick gap
      send(1, 72, 24'h002000);
      wait_gap();
      check("t3_cs_gap", voice_cs, 4'b1110);
      check("t3_freq0", voice_freq[23:0], 24'h002000);
      wait_idle();
      check("t3_cs_back", voice_cs, 4'b1111);
      cyc(); cyc();
      check("t3_count", active_count, 3'd4);

      // retrigger key 64 in voice 2
      send(1, 64, 24'h001800); wait_idle();
      check("t4_freq2", voice_freq[71:48], 24'h001800);
      check("t4_cs", voice_cs, 4'b1111);

      // note-off of an inactive key is dropped
      send(0, 50, 0);
      repeat (N - 1) cyc();
      check("t5_ready_low", ev.ev_ready, 1'b0);
      cyc();
      check("t5_ready_back", ev.ev_ready, 1'b1);
      check("t5_cs", voice_cs, 4'b1111);

      // tick on last scan cycle does not commit
      send(0, 72, 0); wait_idle();
      check("t6_cs_rel", voice_cs, 4'b1110);
      ev.ev_note_on = 1'b1;
      ev.ev_key     = KW'(80);
      ev.ev_freq    = 24'h003000;
      ev.ev_valid   = 1'b1;
      cyc_s(0);
      check("t6_accept", m_acc, 1'b1);
      ev.ev_valid = 1'b0;
      repeat (N - 1) cyc_s(0);
      cyc_s(1);
      check("t6_no_early", voice_cs, 4'b1110);
      cyc_s(0); cyc_s(0);
      check("t6_waiting", busy, 1'b1);
      cyc_s(1);
      check("t6_commit", voice_cs, 4'b1111);
      check("t6_freq0", voice_freq[23:0], 24'h003000);

      // valid held high across two events
      ev.ev_note_on = 1'b0;
      ev.ev_key     = KW'(80);
      ev.ev_valid   = 1'b1;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (m_acc) break;
      end
      ev.ev_note_on = 1'b1;
      ev.ev_key     = KW'(81);
      ev.ev_freq    = 24'h003100;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (m_acc) break;
      end
      ev.ev_valid = 1'b0;
      wait_idle();
      check("t7_cs", voice_cs, 4'b1111);
      check("t7_freq0", voice_freq[23:0], 24'h003100);

      // reset during WAIT_TICK of an allocation
      Reset = 1'b1; cyc_s(0); Reset = 1'b0;
      ev.ev_note_on = 1'b1;
      ev.ev_key     = KW'(60);
      ev.ev_freq    = 24'h001000;
      ev.ev_valid   = 1'b1;
      cyc_s(0);
      ev.ev_valid = 1'b0;
      repeat (N + 2) cyc_s(0);
      check("t8_busy", busy, 1'b1);
      Reset = 1'b1; cyc_s(0); Reset = 1'b0;
      check("t8_ready", ev.ev_ready, 1'b1);
      check("t8_cs", voice_cs, 4'b0000);
      cyc_s(1); cyc_s(0); cyc_s(0);
      check("t8_no_commit", voice_cs, 4'b0000);
      check("t8_count", active_count, 3'd0);

      // reset during GAP of a steal
      send(1, 1, 24'h000100); wait_idle();
      send(1, 2, 24'h000200); wait_idle();
      send(1, 3, 24'h000300); wait_idle();
      send(1, 4, 24'h000400); wait_idle();
      send(1, 5, 24'h000500);
      wait_gap();
      check("t9_cs_gap", voice_cs, 4'b1110);
      Reset = 1'b1; cyc_s(0); Reset = 1'b0;
      check("t9_ready", ev.ev_ready, 1'b1);
      check("t9_cs", voice_cs, 4'b0000);
      cyc_s(1); cyc_s(0); cyc_s(0);
      check("t9_no_commit", voice_cs, 4'b0000);
      check("t9_count", active_count, 3'd0);

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
